// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM boot loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        DATA,
        CSUM,
        DONE,
        ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 8 * HDR_BYTES;

    function automatic logic accepts_bytes(input state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == DATA) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs bytes LSB-first into 32-bit words; emits a registered one-cycle word_valid.
module imem_loader_byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clear,
    input  logic        i_shift,
    input  logic        i_last,
    input  logic [7:0]  i_byte,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [23:0] r_shift;

    // r_shift keeps the three most recent bytes; the oldest ends up in [7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shift      <= '0;
            o_word_valid <= 1'b0;
            o_word       <= '0;
        end else begin
            o_word_valid <= i_shift && i_last;
            if (i_clear) begin
                r_shift <= '0;
            end else if (i_shift) begin
                r_shift <= {i_byte, r_shift[23:8]};
                if (i_last)
                    o_word <= {i_byte, r_shift};
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot-time IMEM loader: header + LE words over valid/ready, core held until done.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [31:0]       imem_wdata,
    output logic              core_hold,
    output logic              done,
    output logic              err
);

    state_t             r_state;
    logic [COUNT_W-1:0] r_count;
    logic [ADDR_W:0]    r_widx;
    logic [1:0]         r_bidx;
    logic [ADDR_W-1:0]  r_waddr;
    logic               r_done;
    logic               r_err;
    logic               r_hold;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]         r_xor;
`endif

    logic               w_accept;
    logic               w_data_acc;
    logic               w_word_last;
    logic               w_final;
    logic               w_start_ok;
    logic [COUNT_W-1:0] w_hdr_count;
    logic               w_hdr_bad;

    assign s_ready     = accepts_bytes(r_state);
    assign w_accept    = s_valid && s_ready;
    assign w_data_acc  = w_accept && (r_state == DATA);
    assign w_word_last = w_data_acc && (r_bidx == 2'(BYTES_PER_WORD - 1));
    assign w_final     = w_word_last && ((COUNT_W'(r_widx) + COUNT_W'(1)) == r_count);
    assign w_start_ok  = start && ((r_state == IDLE) || (r_state == DONE) || (r_state == ERR));
    assign w_hdr_count = {s_data, r_count[7:0]};
    assign w_hdr_bad   = (w_hdr_count == '0) || (32'(w_hdr_count) > 32'(DEPTH));

    assign imem_waddr  = r_waddr;
    assign core_hold   = r_hold;
    assign done        = r_done;
    assign err         = r_err;

    imem_loader_byte_packer u_byte_packer (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok),
        .i_shift      (w_data_acc),
        .i_last       (w_word_last),
        .i_byte       (s_data),
        .o_word_valid (imem_we),
        .o_word       (imem_wdata)
    );

    // done/core_hold update while sitting in DONE, i.e. one cycle after the
    // final write strobe, so IMEM is settled before the core leaves reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_waddr <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor   <= '0;
`endif
        end else if (w_start_ok) begin
            r_state <= HDR_LO;
            r_count <= '0;
            r_widx  <= '0;
            r_bidx  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_hold  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor   <= '0;
`endif
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (w_accept && (r_state != CSUM))
                r_xor <= r_xor ^ s_data;
`endif
            case (r_state)
                HDR_LO: begin
                    if (w_accept) begin
                        r_count[7:0] <= s_data;
                        r_state      <= HDR_HI;
                    end
                end
                HDR_HI: begin
                    if (w_accept) begin
                        r_count[15:8] <= s_data;
                        r_widx        <= '0;
                        r_bidx        <= '0;
                        if (w_hdr_bad) begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_accept) begin
                        r_bidx <= r_bidx + 2'd1;
                        if (w_word_last) begin
                            r_waddr <= r_widx[ADDR_W-1:0];
                            r_widx  <= r_widx + 1'b1;
                        end
                        if (w_final) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                            r_state <= CSUM;
`else
                            r_state <= DONE;
`endif
                        end
                    end
                end
                CSUM: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    if (w_accept) begin
                        if (s_data == r_xor) begin
                            r_state <= DONE;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
`else
                    r_state <= ERR;
                    r_err   <= 1'b1;
`endif
                end
                DONE: begin
                    r_done <= 1'b1;
                    r_hold <= 1'b0;
                end
                ERR: begin
                    r_err  <= 1'b1;
                    r_hold <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
